// File: rtl/conv33_stream_if.sv
// Handshake and status bundle between the stream sequencer and its frame source/sink.
`timescale 1ns/1ps
interface conv33_stream_if;
  logic        start;
  logic        in_avail;
  logic        in_inst_input_read_valid;
  logic        buf_en;
  logic        buf_flush;
  logic        out_inst_output_write_en;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        busy;
  logic        done;

  modport master (
    output start, in_avail,
    input  in_inst_input_read_valid, buf_en, buf_flush,
    input  out_inst_output_write_en, out_x, out_y, busy, done
  );

  modport slave (
    input  start, in_avail,
    output in_inst_input_read_valid, buf_en, buf_flush,
    output out_inst_output_write_en, out_x, out_y, busy, done
  );
endinterface

// File: rtl/conv33_stream_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: pulls one raster, gates
// line-buffer advance on valid pixels and flags cycles holding a full window.
`timescale 1ns/1ps
module conv33_stream_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int IN_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  conv33_stream_if.slave bus
);
  localparam logic [31:0] W32      = 32'(IMG_W);
  localparam logic [31:0] H32      = 32'(IMG_H);
  localparam logic [31:0] TOTAL    = W32 * H32;
  localparam logic [15:0] COL_MAX  = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_MAX  = 16'(IMG_H - 1);
  localparam logic [2:0]  LAT_LAST = 3'(IN_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [31:0]       issued_r;
  logic [2:0]        drain_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              flush_r;
  logic [IN_LAT-1:0] pipe_r;
  logic [15:0]       col_r;
  logic [15:0]       row_r;
  logic              write_en_r;
  logic [15:0]       out_x_r;
  logic [15:0]       out_y_r;

  logic              accept_s;
  logic [IN_LAT:0]   chain_s;
  logic              buf_en_s;
  logic              buf_en_next_s;
  logic [15:0]       col_next_s;
  logic [15:0]       row_next_s;
  logic              window_next_s;

  // Accept a pixel while the frame still has pixels left to pull.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == RUN) && bus.in_avail && (issued_r < TOTAL)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // The top of the chain is the registered buffer enable; the bit below it is next cycle's value.
  assign chain_s       = {pipe_r, accept_s};
  assign buf_en_s      = chain_s[IN_LAT];
  assign buf_en_next_s = chain_s[IN_LAT-1];

  // Raster position of the pixel at the buffer input, advanced only by valid pixels.
  always_comb begin
    col_next_s    = col_r;
    row_next_s    = row_r;
    window_next_s = 1'b0;
    if (buf_en_s) begin
      if (col_r == COL_MAX) begin
        col_next_s = 16'd0;
        if (row_r == ROW_MAX) begin
          row_next_s = 16'd0;
        end else begin
          row_next_s = row_r + 16'd1;
        end
      end else begin
        col_next_s = col_r + 16'd1;
        row_next_s = row_r;
      end
    end else begin
      col_next_s = col_r;
      row_next_s = row_r;
    end
    window_next_s = buf_en_next_s && (col_next_s >= 16'd2) && (row_next_s >= 16'd2);
  end

  // Frame control FSM with its registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      issued_r    <= 32'd0;
      drain_cnt_r <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      flush_r     <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      flush_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r  <= RUN;
            issued_r <= 32'd0;
            busy_r   <= 1'b1;
            flush_r  <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        RUN: begin
          busy_r <= 1'b1;
          if (accept_s) begin
            issued_r <= issued_r + 32'd1;
            if (issued_r == (TOTAL - 32'd1)) begin
              state_r     <= DRAIN;
              drain_cnt_r <= LAT_LAST;
            end else begin
              state_r     <= RUN;
            end
          end else begin
            issued_r <= issued_r;
          end
        end
        DRAIN: begin
          busy_r <= 1'b1;
          if (drain_cnt_r == 3'd0) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 3'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Valid pipe, position counters and window flag/coordinates, all aligned to the buffer input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_r     <= '0;
      col_r      <= 16'd0;
      row_r      <= 16'd0;
      write_en_r <= 1'b0;
      out_x_r    <= 16'd0;
      out_y_r    <= 16'd0;
    end else begin
      pipe_r     <= chain_s[IN_LAT-1:0];
      col_r      <= col_next_s;
      row_r      <= row_next_s;
      write_en_r <= window_next_s;
      if (window_next_s) begin
        out_x_r <= col_next_s - 16'd2;
        out_y_r <= row_next_s - 16'd2;
      end else begin
        out_x_r <= out_x_r;
        out_y_r <= out_y_r;
      end
    end
  end

  assign bus.in_inst_input_read_valid = accept_s;
  assign bus.buf_en                   = buf_en_s;
  assign bus.buf_flush                = flush_r;
  assign bus.out_inst_output_write_en = write_en_r;
  assign bus.out_x                    = out_x_r;
  assign bus.out_y                    = out_y_r;
  assign bus.busy                     = busy_r;
  assign bus.done                     = done_r;
endmodule
